ibus_icache: RTL
================

// Module: ibus_icache
// PURPOSE
//  Responder side of the CPU instruction bus: serves fetch requests issued by the PREIF/IF stages.
//  Direct-mapped, read-only instruction cache with a blocking miss FSM and a burst refill port toward the AXI bridge.
//  Uncached (KSEG1) fetches bypass the arrays as single-word reads.
//  Hits return data the cycle after acceptance, so IF samples rdata in the stage following PREIF.
// PARAMETERS
//  SETS        64  number of lines (power of 2); index width IDX_W = log2(SETS)
//  LINE_WORDS  8   32-bit words per line (power of 2); offset width OFF_W = log2(LINE_WORDS)+2
//  TAG_W = 32-IDX_W-OFF_W (derived localparam, not overridable)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  ibus_valid     in   1   fetch request valid
//  ibus_addr      in   32  physical fetch address, word aligned
//  ibus_uncached  in   1   bypass cache for this request
//  ibus_flush     in   1   cancel response of in-flight request
//  ibus_addr_ok   out  1   request accepted this cycle (valid & addr_ok)
//  ibus_data_ok   out  1   rdata valid for oldest accepted, uncancelled request
//  ibus_rdata     out  32  instruction word
//  rd_req         out  1   memory read request, held until rd_rdy
//  rd_type        out  1   0 = single word, 1 = full line burst
//  rd_addr        out  32  line-aligned (burst) or exact (word) address
//  rd_rdy         in   1   memory accepted rd_req
//  ret_valid      in   1   return beat valid
//  ret_last       in   1   final return beat
//  ret_data       in   32  return beat data
//  perf_hit/perf_miss out 32 each; present only with ICACHE_PERF_CNT_EN
// BEHAVIOUR
//  Reset: state=IDLE, all line valid bits 0, addr_ok=1, data_ok=0, rdata=0, rd_req=0, rd_type=0, rd_addr=0.
//  States: IDLE, LOOKUP, MISS, REFILL, RESP.
//  IDLE: addr_ok=1; accept -> latch addr/uncached/cancel=0, read tag/valid/data at index -> LOOKUP.
//  LOOKUP: hit = valid[idx] & tag match & !uncached.
//   hit: data_ok=1 unless cancelled; rdata = word[offset]; addr_ok=1, a new accept stays in LOOKUP, else IDLE.
//   miss or uncached: addr_ok=0 -> MISS.
//  MISS: rd_req=1, rd_type=!uncached, rd_addr={tag,idx,0} or full addr; on rd_rdy -> REFILL.
//  REFILL: each ret_valid writes ret_data into line buffer at beat counter (0..LINE_WORDS-1), counter++;
//   ret_last -> cached: write line+tag, set valid; uncached: no array write -> RESP.
//  RESP: data_ok=1 unless cancelled; rdata = critical word (buffer[offset] or beat 0); addr_ok=0 -> IDLE.
//  addr_ok=0 throughout MISS/REFILL/RESP; at most one request outstanding past LOOKUP.
//  Flush: ibus_flush in any non-IDLE state sets cancel; cancelled request never raises data_ok.
//   Refill in progress always completes and allocates (bursts are not abortable).
//   flush & valid in IDLE/LOOKUP: new request is accepted, cancel applies only to older one.
//  Beat counter wraps mod LINE_WORDS; memory guarantees ret_last on beat LINE_WORDS-1 (word: beat 0); unchecked.
//  Reset mid-MISS/REFILL: FSM to IDLE, outstanding beats ignored (memory side reset together).
//  ibus_rdata is held from last data_ok when data_ok=0.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: perf_hit increments on each LOOKUP hit, perf_miss on each cached miss
//   entering MISS (uncached excluded); both 32-bit wrapping, reset to 0, counted even if cancelled.
//  Undefined: counters and perf ports absent; all other behaviour identical.
// STRUCTURE
//  Cache_Defines.svh: icache_state_t enum, tag/index/offset widths, cache-line typedef, rd_type encodings.
//  Sub-module icache_way_ram: tag+valid+data arrays, synchronous read at accept, line-wide write, reset clears valid.
//  Top holds FSM, request register, line buffer, beat counter, optional counters.
// TESTING
//  Cold fetch 0x1FC0_0000 -> rd_req type=1 addr 0x1FC0_0000, 8 beats, data_ok once with beat 0.
//  Refetch 0x1FC0_0004 after refill -> addr_ok, data_ok next cycle, rdata = beat 1, no rd_req.
//  Back-to-back hits 0x..00,0x..04,0x..08 -> valid held 3 cycles, 3 consecutive data_ok, correct words.
//  Uncached 0xBFC0_0010 (phys 0x1FC0_0010) -> rd_type=0 addr exact; re-access misses again.
//  ibus_flush during REFILL -> no data_ok; later fetch same line hits.
//  rst asserted mid-REFILL -> outputs at reset values next cycle; prior lines miss afterward.

Source files
------------

// File: rtl/ibus_icache_pkg.sv
// ibus_icache_pkg: cache geometry, FSM states, line type and read-type encodings
package ibus_icache_pkg;
    localparam int SETS       = 64;
    localparam int LINE_WORDS = 8;
    localparam int IDX_W      = $clog2(SETS);
    localparam int WRD_W      = $clog2(LINE_WORDS);
    localparam int OFF_W      = WRD_W + 2;
    localparam int TAG_W      = 32 - IDX_W - OFF_W;
    localparam logic RD_WORD  = 1'b0;
    localparam logic RD_LINE  = 1'b1;
    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} icache_state_t;
    typedef logic [LINE_WORDS-1:0][31:0] line_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/ibus_icache_way_ram.sv
// ibus_icache_way_ram: tag/valid/data arrays, synchronous read, line-wide write, reset clears valid
module ibus_icache_way_ram import ibus_icache_pkg::*; (
    input  logic  clk,
    input  logic  rst,
    input  logic  rd_en,
    input  idx_t  rd_idx,
    output logic  rd_valid,
    output tag_t  rd_tag,
    output line_t rd_line,
    input  logic  wr_en,
    input  idx_t  wr_idx,
    input  tag_t  wr_tag,
    input  line_t wr_line
);
    logic [SETS-1:0] valid;
    tag_t            tags [SETS];
    line_t           data [SETS];
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) valid[wr_idx] <= 1'b1;
            if (rd_en) rd_valid <= valid[rd_idx];
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_line;
        end
        if (rd_en) begin
            rd_tag  <= tags[rd_idx];
            rd_line <= data[rd_idx];
        end
    end
endmodule

// File: rtl/ibus_icache.sv
// ibus_icache: direct-mapped blocking I-cache on the fetch bus; ICACHE_PERF_CNT_EN adds perf_hit/perf_miss
module ibus_icache import ibus_icache_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_valid,
    input  logic [31:0] ibus_addr,
    input  logic        ibus_uncached,
    input  logic        ibus_flush,
    output logic        ibus_addr_ok,
    output logic        ibus_data_ok,
    output logic [31:0] ibus_rdata,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);
    icache_state_t    state;
    logic [31:0]      req_addr, rdata_q;
    logic             req_unc, cancel, accept, hit, kill, wr_en, ram_valid;
    logic [WRD_W-1:0] beat, woff, crit;
    tag_t             ram_tag;
    line_t            ram_line, lbuf, fill;
    assign woff         = req_addr[2+:WRD_W];
    assign crit         = req_unc ? '0 : woff;
    assign hit          = state == LOOKUP && ram_valid && ram_tag == req_addr[31-:TAG_W] && !req_unc;
    assign ibus_addr_ok = state == IDLE || hit;
    assign accept       = ibus_valid && ibus_addr_ok;
    assign kill         = cancel || (ibus_flush && state != IDLE);
    assign ibus_data_ok = !kill && (hit || state == RESP);
    assign ibus_rdata   = !ibus_data_ok ? rdata_q : hit ? ram_line[woff] : lbuf[crit];
    assign wr_en        = state == REFILL && ret_valid && ret_last && !req_unc;
    always_comb begin
        fill       = lbuf;
        fill[beat] = ret_data;
    end
    ibus_icache_way_ram u_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (accept),
        .rd_idx   (ibus_addr[OFF_W+:IDX_W]),
        .rd_valid (ram_valid),
        .rd_tag   (ram_tag),
        .rd_line  (ram_line),
        .wr_en    (wr_en),
        .wr_idx   (req_addr[OFF_W+:IDX_W]),
        .wr_tag   (req_addr[31-:TAG_W]),
        .wr_line  (fill)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_addr <= '0;
            req_unc  <= 1'b0;
            cancel   <= 1'b0;
            beat     <= '0;
            rdata_q  <= '0;
            rd_req   <= 1'b0;
            rd_type  <= RD_WORD;
            rd_addr  <= '0;
        end else begin
            rdata_q <= ibus_rdata;
            if (accept) begin
                req_addr <= ibus_addr;
                req_unc  <= ibus_uncached;
                cancel   <= 1'b0;
            end else if (ibus_flush && state != IDLE) begin
                cancel <= 1'b1;
            end
            case (state)
                IDLE:   if (accept) state <= LOOKUP;
                LOOKUP: if (!hit) begin
                            state   <= MISS;
                            rd_req  <= 1'b1;
                            rd_type <= req_unc ? RD_WORD : RD_LINE;
                            rd_addr <= req_unc ? req_addr : {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        end else if (!accept) begin
                            state <= IDLE;
                        end
                MISS:   if (rd_rdy) begin
                            state  <= REFILL;
                            rd_req <= 1'b0;
                            beat   <= '0;
                        end
                REFILL: if (ret_valid) begin
                            lbuf <= fill;
                            beat <= beat + 1'b1;
                            if (ret_last) state <= RESP;
                        end
                RESP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else begin
            if (hit) perf_hit <= perf_hit + 1;
            if (state == LOOKUP && !hit && !req_unc) perf_miss <= perf_miss + 1;
        end
    end
`endif
endmodule
